// File: rtl/bus_request_arbiter.sv
// Bus request arbiter: one registered one-hot grant, a hold timer and a one-cycle turnaround gap.
// Optional ROUND_ROBIN_EN macro: rotating search start instead of fixed lowest-index priority.
module bus_request_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout,
    output logic [IDX_W-1:0]   timeout_idx
);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] mask, mask_next, elig, grant_next;
    logic [IDX_W-1:0]   grant_idx_next, timeout_idx_next, winner;
    logic               timeout_next, found;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;
`endif

    assign elig        = req & ~mask;
    assign grant_valid = |grant;

    // Winner search over eligible requests; found=0 means nobody can be granted.
    always_comb begin : pick
        int j;
        found  = 1'b0;
        winner = '0;
        j      = 0;
`ifdef ROUND_ROBIN_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && elig[j]) begin
                found  = 1'b1;
                winner = IDX_W'(j);
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i]) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        state_next       = state;
        grant_next       = grant;
        grant_idx_next   = grant_idx;
        timeout_next     = 1'b0;
        timeout_idx_next = timeout_idx;
        hold_cnt_next    = hold_cnt;
        mask_next        = mask & req;
`ifdef ROUND_ROBIN_EN
        rr_ptr_next      = rr_ptr;
`endif
        case (state)
            IDLE, GAP: begin
                grant_next = '0;
                if (enable && found) begin
                    grant_next[winner] = 1'b1;
                    grant_idx_next     = winner;
                    hold_cnt_next      = '0;
                    state_next         = OWN;
`ifdef ROUND_ROBIN_EN
                    rr_ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            OWN: begin
                // A timed-out owner is masked so it cannot win again until it drops req.
                if (!req[grant_idx]) begin
                    grant_next = '0;
                    state_next = GAP;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                    grant_next           = '0;
                    timeout_next         = 1'b1;
                    timeout_idx_next     = grant_idx;
                    mask_next[grant_idx] = 1'b1;
                    state_next           = GAP;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
            timeout_idx <= '0;
            hold_cnt    <= '0;
            mask        <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= '0;
`endif
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            grant_idx   <= grant_idx_next;
            timeout     <= timeout_next;
            timeout_idx <= timeout_idx_next;
            hold_cnt    <= hold_cnt_next;
            mask        <= mask_next;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= rr_ptr_next;
`endif
        end
    end
endmodule

// File: tb/tb_bus_request_arbiter.sv
// Self-checking bench for bus_request_arbiter: a MAX_HOLD=16 instance and a MAX_HOLD=0 instance
// share rst/enable; expected outputs are queued on every drive and compared one edge later.
module tb_bus_request_arbiter;
    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] req, req_b;
    logic [7:0] grant, grant_b;
    logic [2:0] grant_idx, grant_idx_b, timeout_idx, timeout_idx_b;
    logic       grant_valid, grant_valid_b, timeout, timeout_b;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] req_b;
        logic [7:0] exp_grant;
        logic [7:0] exp_grant_b;
        logic       exp_to;
        logic [2:0] exp_to_idx;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;

    bus_request_arbiter #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
        .timeout(timeout), .timeout_idx(timeout_idx)
    );

    bus_request_arbiter #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(0)) dut_nohold (
        .clk(clk), .rst(rst), .enable(enable), .req(req_b),
        .grant(grant_b), .grant_idx(grant_idx_b), .grant_valid(grant_valid_b),
        .timeout(timeout_b), .timeout_idx(timeout_idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic r, logic e, logic [7:0] rq, logic [7:0] g,
                                logic to, logic [2:0] ti);
        vec_t v;
        v.rst = r;  v.en = e;  v.req = rq;  v.req_b = 8'h00;
        v.exp_grant = g;  v.exp_grant_b = 8'h00;
        v.exp_to = to;  v.exp_to_idx = ti;
        return v;
    endfunction

    function automatic int idx_of(logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int owner_at(int n);
`ifdef ROUND_ROBIN_EN
        return n % 8;
`else
        return n % 2;
`endif
    endfunction

    task automatic check(string name, int unsigned act, int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue expected an entry", step);
            return;
        end
        e = exp_q.pop_front();
        check("grant", grant, e.exp_grant);
        check("grant_valid", grant_valid, |e.exp_grant);
        check("timeout", timeout, e.exp_to);
        if (|e.exp_grant) check("grant_idx", grant_idx, idx_of(e.exp_grant));
        if (e.exp_to) check("timeout_idx", timeout_idx, e.exp_to_idx);
        check("grant_b", grant_b, e.exp_grant_b);
        check("grant_valid_b", grant_valid_b, |e.exp_grant_b);
        check("timeout_b", timeout_b, 0);
        if (|e.exp_grant_b) check("grant_idx_b", grant_idx_b, idx_of(e.exp_grant_b));
        if (e.rst) begin
            check("grant_idx_rst", grant_idx, 0);
            check("timeout_idx_rst", timeout_idx, 0);
            check("grant_idx_b_rst", grant_idx_b, 0);
            check("timeout_idx_b_rst", timeout_idx_b, 0);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        enable = v.en;
        req    = v.req;
        req_b  = v.req_b;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        step++;
        checkOutput();
    endtask

    initial begin
        vec_t v;
        int   cur;
        rst = 1'b1;  enable = 1'b0;  req = '0;  req_b = '0;

        // Directed table: reset, priority + gap, pending request, enable gating, reset mid-ownership.
        tbl.push_back(mk(1, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 8'h04, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h04, 8'h04, 0, 0));
        tbl.push_back(mk(0, 1, 8'h04, 8'h04, 0, 0));
        tbl.push_back(mk(0, 1, 8'h14, 8'h04, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 8'h10, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 8'h10, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 8'h10, 0, 0));
        tbl.push_back(mk(0, 0, 8'h10, 8'h10, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h04, 8'h04, 0, 0));
        tbl.push_back(mk(0, 1, 8'h04, 8'h04, 0, 0));
        tbl.push_back(mk(1, 1, 8'h04, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h0A, 8'h02, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 8'h00, 0, 0));
        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Hold timeout: 16 grant cycles, one pulse, then masked until req[3] drops.
        for (int k = 1; k <= 40; k++)
            applyStimulus(mk(0, 1, 8'h08, (k <= 16) ? 8'h08 : 8'h00, k == 17, 3'd3));
        applyStimulus(mk(0, 1, 8'h00, 8'h00, 0, 0));
        applyStimulus(mk(0, 1, 8'h08, 8'h08, 0, 0));
        applyStimulus(mk(0, 1, 8'h00, 8'h00, 0, 0));
        applyStimulus(mk(0, 1, 8'h00, 8'h00, 0, 0));

        // All requesting; each owner releases for the release edge and the next arbitration edge.
        applyStimulus(mk(1, 1, 8'h00, 8'h00, 0, 0));
        applyStimulus(mk(0, 1, 8'hFF, 8'h01, 0, 0));
        for (int n = 0; n < 9; n++) begin
            cur = owner_at(n);
            applyStimulus(mk(0, 1, 8'hFF, 8'(1) << cur, 0, 0));
            applyStimulus(mk(0, 1, 8'hFF, 8'(1) << cur, 0, 0));
            if (n < 8) begin
                applyStimulus(mk(0, 1, ~(8'(1) << cur), 8'h00, 0, 0));
                applyStimulus(mk(0, 1, ~(8'(1) << cur), 8'(1) << owner_at(n + 1), 0, 0));
            end
        end
        applyStimulus(mk(0, 1, 8'h00, 8'h00, 0, 0));
        applyStimulus(mk(0, 1, 8'h00, 8'h00, 0, 0));

        // MAX_HOLD=0 instance: grant held for 200 cycles with no timeout.
        for (int k = 0; k < 200; k++) begin
            v = mk(0, 1, 8'h00, 8'h00, 0, 0);
            v.req_b = 8'h20;
            v.exp_grant_b = 8'h20;
            applyStimulus(v);
        end
        applyStimulus(mk(0, 1, 8'h00, 8'h00, 0, 0));
        applyStimulus(mk(0, 1, 8'h00, 8'h00, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
